dmem_arbiter: RTL

// Two-port arbiter and access sequencer in front of the single-port DMEM (async read, sync write).

---
 rtl/dmem_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter and one-cycle access sequencer in front of a single-port DMEM.
// Optional feature macro DMEM_ARB_RR_EN selects round-robin arbitration (default: fixed, port 0 first).
module dmem_arbiter #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             m0_req,
   input  logic             m0_we,
   input  logic [WIDTH-1:0] m0_addr,
   input  logic [WIDTH-1:0] m0_wdata,
   input  logic [2:0]       m0_ctrl,
   output logic             m0_gnt,
   output logic             m0_done,
   output logic             m0_err,
   output logic [WIDTH-1:0] m0_rdata,
   input  logic             m1_req,
   input  logic             m1_we,
   input  logic [WIDTH-1:0] m1_addr,
   input  logic [WIDTH-1:0] m1_wdata,
   input  logic [2:0]       m1_ctrl,
   output logic             m1_gnt,
   output logic             m1_done,
   output logic             m1_err,
   output logic [WIDTH-1:0] m1_rdata,
   output logic [WIDTH-1:0] mem_addr,
   output logic             mem_we,
   output logic             mem_re,
   output logic [WIDTH-1:0] mem_wdata,
   output logic [2:0]       mem_ctrl,
   input  logic [WIDTH-1:0] mem_rdata,
   output logic             busy
);

   localparam int unsigned IDX_W = WIDTH - 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic             src;
   logic             any_req;
   logic             sel;
   logic             start;
   logic             resp_src;
   logic             cand_we;
   logic [WIDTH-1:0] cand_addr;
   logic [WIDTH-1:0] cand_wdata;
   logic [2:0]       cand_ctrl;
   logic             cand_err;

   // Misalignment, illegal funct3 for the direction, or word index beyond DMEM.
   function automatic logic access_bad(input logic we, input logic [WIDTH-1:0] addr,
                                       input logic [2:0] ctrl);
      logic bad;
      bad = ((ctrl[1:0] == 2'b01) && addr[0]) ||
            ((ctrl[1:0] == 2'b10) && (addr[1:0] != 2'b00));
      if (we) bad = bad || ctrl[2] || (ctrl[1:0] == 2'b11);
      else    bad = bad || (ctrl == 3'b011) || (ctrl[2:1] == 2'b11);
      bad = bad || (addr[WIDTH-1:2] >= IDX_W'(DEPTH));
      return bad;
   endfunction

   // Requests are masked while reset is asserted so gnt also reads 0 then.
   assign any_req = rst_n & (m0_req | m1_req);

`ifdef DMEM_ARB_RR_EN
   logic last_grant;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 last_grant <= 1'b0;
      else if (m0_gnt || m1_gnt)  last_grant <= m1_gnt;
   end

   assign sel = (m0_req & m1_req) ? ~last_grant : m1_req;
`else
   assign sel = ~m0_req;
`endif

   assign cand_we    = sel ? m1_we    : m0_we;
   assign cand_addr  = sel ? m1_addr  : m0_addr;
   assign cand_wdata = sel ? m1_wdata : m0_wdata;
   assign cand_ctrl  = sel ? m1_ctrl  : m0_ctrl;
   assign cand_err   = access_bad(cand_we, cand_addr, cand_ctrl);

   assign start    = (state == IDLE) && any_req;
   assign resp_src = (state == IDLE) ? sel : src;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      m0_gnt     = 1'b0;
      m1_gnt     = 1'b0;
      case (state)
         IDLE: begin
            if (any_req) begin
               m0_gnt     = ~sel;
               m1_gnt     = sel;
               state_next = cand_err ? RESP : ACCESS;
            end
         end
         ACCESS:  state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // mem_* hold the latched command only for the ACCESS cycle; done/err mark the RESP cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         src       <= 1'b0;
         busy      <= 1'b0;
         mem_addr  <= '0;
         mem_we    <= 1'b0;
         mem_re    <= 1'b0;
         mem_wdata <= '0;
         mem_ctrl  <= 3'b000;
         m0_done   <= 1'b0;
         m1_done   <= 1'b0;
         m0_err    <= 1'b0;
         m1_err    <= 1'b0;
         m0_rdata  <= '0;
         m1_rdata  <= '0;
      end else begin
         busy      <= (state_next != IDLE);
         mem_addr  <= '0;
         mem_we    <= 1'b0;
         mem_re    <= 1'b0;
         mem_wdata <= '0;
         mem_ctrl  <= 3'b000;
         if (start) src <= sel;
         if (start && !cand_err) begin
            mem_addr  <= cand_addr;
            mem_we    <= cand_we;
            mem_re    <= ~cand_we;
            mem_wdata <= cand_wdata;
            mem_ctrl  <= cand_ctrl;
         end
         m0_done <= (state_next == RESP) && !resp_src;
         m1_done <= (state_next == RESP) &&  resp_src;
         m0_err  <= start && cand_err && !sel;
         m1_err  <= start && cand_err &&  sel;
         if (mem_re && !src) m0_rdata <= mem_rdata;
         if (mem_re &&  src) m1_rdata <= mem_rdata;
      end
   end

endmodule
